bus_cycle_pins: RTL and testbench
=================================

BUS_CYCLE_PINS -- requirements
Module: bus_cycle_pins

Interface
REQ-001 Parameter AW, default 16, address pin width.
REQ-002 Parameter DW, default 8, data pin width.
REQ-003 Parameter FORCED_WAIT, default 0, unconditional wait states per cycle (legal 0..7).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 nreset  input  1  reset, synchronous, active-low.
REQ-006 req  input  1  core requests a bus cycle.
REQ-007 we  input  1  1 = write cycle, 0 = read cycle; sampled with req.
REQ-008 addr  input  AW  cycle address; sampled with req.
REQ-009 wdata  input  DW  write data; sampled with req.
REQ-010 rdata  output  DW  last read data, held until the next read completes.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse in T3.
REQ-013 bus_float  input  1  tri-state all pins; external bus grant.
REQ-014 A  output  AW  address pins, tri-statable.
REQ-015 D  inout  DW  bidirectional data pins.
REQ-016 nMREQ, nRD, nWR  output  1 each  active-low strobes, tri-statable.
REQ-017 nWAIT  input  1  active-low wait request from memory.

Function
REQ-018 FSM states: IDLE, T1, T2, TW, T3.
REQ-019 IDLE -> T1 when req=1 and bus_float=0; addr, we, wdata are latched on that edge.
REQ-020 T1: A drives the latched address; nMREQ=0; nRD=0 when the cycle is a read.
REQ-021 T2: nMREQ stays low; nWR=0 when the cycle is a write; D drives the latched wdata from T2 through T3 of a write.
REQ-022 Wait-counter behaviour:
- Counter loads FORCED_WAIT on entry to T2.
- T2 or TW -> TW while counter != 0 or nWAIT=0; counter decrements in TW until it reaches 0.
- Otherwise T2 or TW -> T3.
REQ-023 Read capture: D is captured into rdata on the edge that enters T3.
REQ-024 T3 strobe and handshake behaviour:
- All strobes are inactive (high).
- done=1.
- Next state is T1 if req=1 and bus_float=0, with the new request latched back-to-back.
- Otherwise next state is IDLE.
REQ-025 Hold behaviour: the address latch holds its last value, and A keeps driving it in IDLE while bus_float=0.
REQ-026 D tri-state: D is Z in IDLE, in all states of a read cycle, and whenever bus_float=1.
REQ-027 Float: bus_float=1 tri-states A, D, nMREQ, nRD and nWR within the same cycle, combinationally.
REQ-028 Float mid-cycle: bus_float asserted mid-cycle does not abort the FSM; the cycle completes internally, done pulses, and no new request is accepted.
REQ-029 Ignored requests: req while busy=1 is ignored except in T3.

Reset
REQ-030 On the edge where nreset=0, outputs and state take these values:
- State: IDLE.
- Strobes: high.
- Address latch: 0.
- D: Z.
- rdata, done, busy, wait counter: 0.
REQ-031 Reset asserted mid-cycle puts all strobes inactive on the next edge; no done pulse is produced.

Configuration
REQ-032 Macro BUS_WAIT_PIN_EN, when defined, makes nWAIT extend the cycle as in REQ-022.
REQ-033 Without BUS_WAIT_PIN_EN, nWAIT is ignored and only FORCED_WAIT inserts TW states; with FORCED_WAIT=0, TW is unreachable.

Structure
REQ-034 Package bus_pkg holds the FSM state enum and the AW/DW default constants.
REQ-035 Sub-module bus_wait_ctl contains the wait counter and TW decision logic.
REQ-036 Address latch, data latch and tri-state drivers stay in bus_cycle_pins.

Verification
REQ-037 Read test: read addr=AA55, memory drives D=3C, FORCED_WAIT=0, nWAIT=1.
- A=AA55 from T1.
- nRD low for 2 cycles.
- rdata=3C.
- done pulses on cycle 3 after accept.
REQ-038 Write test: write addr=1234, wdata=55.
- nWR low only in T2.
- D=55 through T2 and T3.
- D=Z in the cycle after T3.
REQ-039 Wait test: BUS_WAIT_PIN_EN defined, nWAIT=0 for 3 cycles after T2 -> exactly 3 TW states, then done.
REQ-040 Forced-wait test: FORCED_WAIT=2, nWAIT tied high -> 2 TW states; with the macro undefined, nWAIT=0 has no effect.
REQ-041 Back-to-back test: req held high across two requests -> T3 goes directly to T1 and the second address appears without an IDLE cycle.
REQ-042 Float and reset test:
- bus_float=1 in T2 makes A, D and the strobes Z immediately, and done still pulses.
- nreset=0 in TW makes the strobes high on the next edge, busy=0 and no done pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default pin widths for the bus cycle engine and its wait controller.
package bus_pkg;

    localparam int BUS_AW  = 16;
    localparam int BUS_DW  = 8;
    localparam int WAIT_CW = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3
    } bus_state_e;

endpackage

// File: rtl/bus_wait_ctl.sv
// Wait-state counter and TW decision for the bus cycle engine.
// nWAIT only participates when BUS_WAIT_PIN_EN is defined.
module bus_wait_ctl
    import bus_pkg::*;
#(
    parameter int FORCED_WAIT = 0
) (
    input  logic       clk,
    input  logic       nreset,
    input  bus_state_e state,
    input  logic       nwait,
    output logic       wait_req
);

    logic [WAIT_CW-1:0] cnt_q;
    logic [WAIT_CW-1:0] cnt_d;
    logic               pin_wait;

`ifdef BUS_WAIT_PIN_EN
    assign pin_wait = !nwait;
`else
    logic unused_nwait;
    assign unused_nwait = nwait;
    assign pin_wait     = 1'b0;
`endif

    // Load in T1 so the count is valid in T2; a nonzero count always forces TW,
    // so decrementing on every T2/TW edge yields exactly FORCED_WAIT TW states.
    always_comb begin
        cnt_d = cnt_q;
        if (state == ST_T1) begin
            cnt_d = WAIT_CW'(FORCED_WAIT);
        end else if ((state == ST_T2 || state == ST_TW) && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_req = (cnt_q != '0) || pin_wait;

endmodule

// File: rtl/bus_cycle_pins.sv
// External bus cycle engine (IDLE/T1/T2/TW/T3) with tri-statable address, data and strobes.
// Define BUS_WAIT_PIN_EN to let nWAIT stretch cycles with extra TW states.
module bus_cycle_pins
    import bus_pkg::*;
#(
    parameter int AW          = BUS_AW,
    parameter int DW          = BUS_DW,
    parameter int FORCED_WAIT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    input  logic          bus_float,
    output wire  [AW-1:0] A,
    inout  wire  [DW-1:0] D,
    output wire           nMREQ,
    output wire           nRD,
    output wire           nWR,
    input  logic          nWAIT
);

    bus_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nmreq_q, nmreq_d;
    logic          nrd_q, nrd_d;
    logic          nwr_q, nwr_d;
    logic          d_oe_q, d_oe_d;
    logic          accept;
    logic          in_cycle;
    logic          wait_req;

    bus_wait_ctl #(
        .FORCED_WAIT(FORCED_WAIT)
    ) u_wait (
        .clk     (clk),
        .nreset  (nreset),
        .state   (state_q),
        .nwait   (nWAIT),
        .wait_req(wait_req)
    );

    // Strobes and data enable are computed from the next state so the pins
    // come straight from flops.
    always_comb begin
        accept  = req && !bus_float && (state_q == ST_IDLE || state_q == ST_T3);
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_T1;
            ST_T1:        state_d = ST_T2;
            ST_T2, ST_TW: state_d = wait_req ? ST_TW : ST_T3;
            ST_T3:        state_d = accept ? ST_T1 : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        if (accept) begin
            addr_d  = addr;
            we_d    = we;
            wdata_d = wdata;
        end

        if (state_d == ST_T3 && !we_q) begin
            rdata_d = D;
        end

        in_cycle = (state_d == ST_T1 || state_d == ST_T2 || state_d == ST_TW);
        nmreq_d  = !in_cycle;
        nrd_d    = !(in_cycle && !we_d);
        nwr_d    = !((state_d == ST_T2 || state_d == ST_TW) && we_d);
        d_oe_d   = we_d && (state_d == ST_T2 || state_d == ST_TW || state_d == ST_T3);
        done_d   = (state_d == ST_T3);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nmreq_q <= 1'b1;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            d_oe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nmreq_q <= nmreq_d;
            nrd_q   <= nrd_d;
            nwr_q   <= nwr_d;
            d_oe_q  <= d_oe_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // bus_float releases every pin in the same cycle; the FSM keeps running.
    assign A     = bus_float ? {AW{1'bz}} : addr_q;
    assign D     = (d_oe_q && !bus_float) ? wdata_q : {DW{1'bz}};
    assign nMREQ = bus_float ? 1'bz : nmreq_q;
    assign nRD   = bus_float ? 1'bz : nrd_q;
    assign nWR   = bus_float ? 1'bz : nwr_q;

endmodule

// File: tb/tb_bus_cycle_pins.sv
// Directed bench for bus_cycle_pins: vector table plus multi-cycle wait, float and reset sequences.
`timescale 1ns/1ps
module tb_bus_cycle_pins;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NV = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nreset;
    logic          req, we, bus_float, nwait, mem_oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mem_data, rdata;
    logic          busy, done;
    // Address and data pins pull high, strobes pull low, so a released strobe
    // reads differently from an inactive-high one.
    tri1 [AW-1:0]  a_pins;
    tri1 [DW-1:0]  d_pins;
    tri0           nmreq, nrd, nwr;

    logic          req_w, we_w, flt_w, nwait_w, moe_w;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] wdata_w, mdata_w, rdata_w;
    logic          busy_w, done_w;
    tri1 [AW-1:0]  a_w;
    tri1 [DW-1:0]  d_w;
    tri0           nmreq_w, nrd_w, nwr_w;

    assign d_pins = mem_oe ? mem_data : {DW{1'bz}};
    assign d_w    = moe_w ? mdata_w : {DW{1'bz}};

    bus_cycle_pins #(.AW(AW), .DW(DW), .FORCED_WAIT(0)) dut (
        .clk(clk), .nreset(nreset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .bus_float(bus_float),
        .A(a_pins), .D(d_pins), .nMREQ(nmreq), .nRD(nrd), .nWR(nwr), .nWAIT(nwait)
    );

    bus_cycle_pins #(.AW(AW), .DW(DW), .FORCED_WAIT(2)) dut_w (
        .clk(clk), .nreset(nreset), .req(req_w), .we(we_w), .addr(addr_w), .wdata(wdata_w),
        .rdata(rdata_w), .busy(busy_w), .done(done_w), .bus_float(flt_w),
        .A(a_w), .D(d_w), .nMREQ(nmreq_w), .nRD(nrd_w), .nWR(nwr_w), .nWAIT(nwait_w)
    );

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          flt;
        logic          moe;
        logic [DW-1:0] mdata;
        logic          busy;
        logic          done;
        logic [2:0]    strb;    // {nMREQ, nRD, nWR}
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic rq, logic w, logic [AW-1:0] ad, logic [DW-1:0] wd,
                                logic fl, logic mo, logic [DW-1:0] md, logic b, logic dn,
                                logic [2:0] st, logic [AW-1:0] ea, logic [DW-1:0] ed,
                                logic [DW-1:0] er);
        vec_t v;
        v.req = rq; v.we = w; v.addr = ad; v.wdata = wd; v.flt = fl; v.moe = mo; v.mdata = md;
        v.busy = b; v.done = dn; v.strb = st; v.a = ea; v.d = ed; v.rdata = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_edge;

        // Read AA55 <- 3C, write 1234/55, back-to-back read then write, float while idle.
        vecs[0]  = mk(1, 0, 16'hAA55, 8'h00, 0, 0, 8'h00, 1, 0, 3'b001, 16'hAA55, 8'hFF, 8'h00);
        vecs[1]  = mk(0, 0, 16'h0000, 8'h00, 0, 1, 8'h3C, 1, 0, 3'b001, 16'hAA55, 8'h3C, 8'h00);
        vecs[2]  = mk(0, 0, 16'h0000, 8'h00, 0, 1, 8'h3C, 1, 1, 3'b111, 16'hAA55, 8'h3C, 8'h3C);
        vecs[3]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 3'b111, 16'hAA55, 8'hFF, 8'h3C);
        vecs[4]  = mk(1, 1, 16'h1234, 8'h55, 0, 0, 8'h00, 1, 0, 3'b011, 16'h1234, 8'hFF, 8'h3C);
        vecs[5]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 0, 3'b010, 16'h1234, 8'h55, 8'h3C);
        vecs[6]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 1, 3'b111, 16'h1234, 8'h55, 8'h3C);
        vecs[7]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 3'b111, 16'h1234, 8'hFF, 8'h3C);
        vecs[8]  = mk(1, 0, 16'h0F0F, 8'h00, 0, 0, 8'h00, 1, 0, 3'b001, 16'h0F0F, 8'hFF, 8'h3C);
        vecs[9]  = mk(1, 1, 16'h5A5A, 8'hA5, 0, 1, 8'h66, 1, 0, 3'b001, 16'h0F0F, 8'h66, 8'h3C);
        vecs[10] = mk(1, 1, 16'h5A5A, 8'hA5, 0, 1, 8'h66, 1, 1, 3'b111, 16'h0F0F, 8'h66, 8'h66);
        vecs[11] = mk(1, 1, 16'h5A5A, 8'hA5, 0, 0, 8'h00, 1, 0, 3'b011, 16'h5A5A, 8'hFF, 8'h66);
        vecs[12] = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 0, 3'b010, 16'h5A5A, 8'hA5, 8'h66);
        vecs[13] = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 1, 3'b111, 16'h5A5A, 8'hA5, 8'h66);
        vecs[14] = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 3'b111, 16'h5A5A, 8'hFF, 8'h66);
        vecs[15] = mk(1, 0, 16'h1111, 8'h00, 1, 0, 8'h00, 0, 0, 3'b000, 16'hFFFF, 8'hFF, 8'h66);
        vecs[16] = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 3'b111, 16'h5A5A, 8'hFF, 8'h66);

        nreset = 1'b0; req = 0; we = 0; addr = '0; wdata = '0; bus_float = 0; nwait = 1;
        mem_oe = 0; mem_data = '0;
        req_w = 0; we_w = 0; addr_w = '0; wdata_w = '0; flt_w = 0; nwait_w = 1;
        moe_w = 0; mdata_w = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.strb", {nmreq, nrd, nwr}, 3'b111);
        check("rst.A", a_pins, 16'h0000);
        check("rst.D", d_pins, 8'hFF);
        check("rst.rdata", rdata, 8'h00);
        check("rst.busy_w", busy_w, 0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            bus_float = vecs[i].flt; mem_oe = vecs[i].moe; mem_data = vecs[i].mdata;
            @(posedge clk);
            #1;
            $display("[TB] vec %0d req=%0b we=%0b addr=%h -> busy=%0b done=%0b A=%h D=%h rdata=%h",
                     i, vecs[i].req, vecs[i].we, vecs[i].addr, busy, done, a_pins, d_pins, rdata);
            check($sformatf("v%0d.busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d.done", i), done, vecs[i].done);
            check($sformatf("v%0d.strb", i), {nmreq, nrd, nwr}, vecs[i].strb);
            check($sformatf("v%0d.A", i), a_pins, vecs[i].a);
            check($sformatf("v%0d.D", i), d_pins, vecs[i].d);
            check($sformatf("v%0d.rdata", i), rdata, vecs[i].rdata);
        end

        // Float asserted in T2 of a write: pins release at once, cycle still completes.
        @(negedge clk);
        req = 1; we = 1; addr = 16'h2222; wdata = 8'h77; bus_float = 0; mem_oe = 0;
        @(posedge clk);
        @(negedge clk);
        req = 0;
        @(posedge clk);
        #1;
        check("flt.t2.nwr", nwr, 0);
        check("flt.t2.D", d_pins, 8'h77);
        @(negedge clk);
        bus_float = 1; req = 1; we = 0; addr = 16'h4444;
        #1;
        check("flt.A", a_pins, 16'hFFFF);
        check("flt.D", d_pins, 8'hFF);
        check("flt.nrd", nrd, 0);
        @(posedge clk);
        #1;
        check("flt.t3.done", done, 1);
        check("flt.t3.busy", busy, 1);
        @(posedge clk);
        #1;
        check("flt.noaccept.busy", busy, 0);
        check("flt.noaccept.done", done, 0);
        @(negedge clk);
        bus_float = 0; req = 0;
        #1;
        check("flt.release.A", a_pins, 16'h2222);
        $display("[TB] float-in-T2 write sequence complete");

        // nWAIT low for three cycles starting in T2 on the zero-forced-wait instance.
        @(negedge clk);
        req = 1; we = 0; addr = 16'h4321; mem_oe = 1; mem_data = 8'hC3;
        done_edge = 0;
        for (int k = 1; k <= 12 && done_edge == 0; k++) begin
            if (k > 1) begin
                @(negedge clk);
                req = 0;
                nwait = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) done_edge = k;
        end
`ifdef BUS_WAIT_PIN_EN
        check("wait.done_edge", done_edge, 6);
`else
        check("wait.done_edge", done_edge, 3);
`endif
        check("wait.rdata", rdata, 8'hC3);
        @(negedge clk);
        nwait = 1; mem_oe = 0;
        $display("[TB] nWAIT read done on edge %0d", done_edge);

        // FORCED_WAIT=2: two TW states regardless of nWAIT in the default build.
        @(negedge clk);
        req_w = 1; we_w = 0; addr_w = 16'h3333; moe_w = 1; mdata_w = 8'h9D;
`ifdef BUS_WAIT_PIN_EN
        nwait_w = 1;
`else
        nwait_w = 0;
`endif
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(negedge clk);
                req_w = 0;
            end
            @(posedge clk);
            #1;
            check($sformatf("fw.e%0d.done", k), done_w, (k == 5) ? 1 : 0);
            check($sformatf("fw.e%0d.nrd", k), nrd_w, (k <= 4) ? 0 : 1);
        end
        check("fw.rdata", rdata_w, 8'h9D);
        check("fw.busy", busy_w, 0);
        $display("[TB] forced-wait read rdata=%h", rdata_w);

        // Reset asserted in TW: strobes inactive next edge, no done pulse.
        @(negedge clk);
        nwait_w = 1; moe_w = 0;
        req_w = 1; we_w = 0; addr_w = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        req_w = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tw.in_tw.nrd", nrd_w, 0);
        @(negedge clk);
        nreset = 0;
        @(posedge clk);
        #1;
        check("rst_tw.strb", {nmreq_w, nrd_w, nwr_w}, 3'b111);
        check("rst_tw.busy", busy_w, 0);
        check("rst_tw.done", done_w, 0);
        @(negedge clk);
        nreset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tw.after.done", done_w, 0);
        check("rst_tw.after.busy", busy_w, 0);
        $display("[TB] reset-in-TW sequence complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
